// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM states, Booth digit-select codes and digit-count helper for booth_seq_mult.
package booth_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2:0] ZERO = 3'd0;
   localparam logic [2:0] POS1 = 3'd1;
   localparam logic [2:0] NEG1 = 3'd2;
   localparam logic [2:0] POS2 = 3'd3;
   localparam logic [2:0] NEG2 = 3'd4;

   function automatic int num_digits(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// booth_digit_sel: maps a radix-4 Booth group {b[1],b[0],lookback} to 0, +-M or +-2M.
module booth_digit_sel
   import booth_pkg::*;
#(
   parameter int WIDTH = 14
) (
   input  logic [2:0]         grp,
   input  logic [2*WIDTH+1:0] m,
   output logic [2*WIDTH+1:0] pp
);

   logic [2:0] sel;

   always_comb begin
      sel = (grp == 3'b001 || grp == 3'b010) ? POS1 :
            (grp == 3'b101 || grp == 3'b110) ? NEG1 :
            (grp == 3'b011)                  ? POS2 :
            (grp == 3'b100)                  ? NEG2 : ZERO;
      pp  = (sel == POS1) ? m :
            (sel == NEG1) ? -m :
            (sel == POS2) ? (m << 1) :
            (sel == NEG2) ? -(m << 1) : '0;
   end

endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define BOOTH_EARLY_TERM_EN to leave RUN as soon as all remaining Booth digits are zero.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int ND = num_digits(WIDTH);
   localparam int AW = 2*WIDTH + 2;
   localparam int BW = 2*ND;
   localparam int CW = $clog2(ND);

   state_t          state, state_nxt;
   logic [AW-1:0]   m_reg, acc, pp;
   logic [BW-1:0]   b_reg;
   logic            lb;
   logic [CW-1:0]   cnt;
   logic            last;
   logic            a_s, b_s;

   assign a_s = signed_mode & multiplicand[WIDTH-1];
   assign b_s = signed_mode & multiplier[WIDTH-1];

   booth_digit_sel #(.WIDTH(WIDTH)) u_sel (
      .grp (({b_reg[1:0], lb})),
      .m   (m_reg),
      .pp  (pp)
   );

`ifdef BOOTH_EARLY_TERM_EN
   // remaining bits plus the next lookback all equal means every later digit is zero
   assign last = (cnt == CW'(ND-1)) || (&b_reg[BW-1:1]) || !(|b_reg[BW-1:1]);
`else
   assign last = (cnt == CW'(ND-1));
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = in_valid  ? RUN  : IDLE;
         RUN:     state_nxt = last      ? DONE : RUN;
         DONE:    state_nxt = out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         m_reg <= '0;
         acc   <= '0;
         b_reg <= '0;
         lb    <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_valid) begin
            m_reg <= {{(AW-WIDTH){a_s}}, multiplicand};
            b_reg <= {{(BW-WIDTH){b_s}}, multiplier};
            lb    <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
         end else if (state == RUN) begin
            acc   <= acc + pp;
            lb    <= b_reg[1];
            b_reg <= {{2{b_reg[BW-1]}}, b_reg[BW-1:2]};
            m_reg <= m_reg << 2;
            cnt   <= cnt + 1'b1;
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == RUN);
   assign out_valid = (state == DONE);
   assign product   = acc[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: random and directed operands checked against an arithmetic product/latency model.
module tb_booth_seq_mult;

   localparam int W  = 14;
   localparam int ND = W/2 + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  multiplicand = '0;
   logic [W-1:0]  multiplier = '0;
   logic          signed_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [2*W-1:0] product;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   booth_seq_mult #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .signed_mode  (signed_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic longint model_product(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      longint p;
      p = s ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
      return p & 64'h0FFF_FFFF;
   endfunction

   function automatic int bit_of(input logic [W-1:0] b, input logic s, input int k);
      if (k < 0) return 0;
      if (k >= W) return s ? int'(b[W-1]) : 0;
      return int'(b[k]);
   endfunction

   // number of RUN cycles: ND, or with early termination up to the last nonzero Booth digit
   function automatic int model_latency(input logic [W-1:0] b, input logic s);
      int last_nz = 0;
      for (int i = 0; i < ND; i++) begin
         int d;
         d = -2*bit_of(b, s, 2*i+1) + bit_of(b, s, 2*i) + bit_of(b, s, 2*i-1);
         if (d != 0) last_nz = i;
      end
`ifdef BOOTH_EARLY_TERM_EN
      return last_nz + 1;
`else
      return (last_nz >= 0) ? ND : ND;
`endif
   endfunction

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
      int lat, busy_n;
      longint exp_p;
      exp_p = model_product(a, b, s);
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      multiplicand = a;
      multiplier   = b;
      signed_mode  = s;
      in_valid     = 1'b1;
      out_ready    = 1'b0;
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      signed_mode  = 1'($urandom);
      lat = 0;
      busy_n = 0;
      while (!out_valid && lat < 40) begin
         if (busy) busy_n++;
         if (lat == 2) begin
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, model_latency(b, s));
      check("busy_cycles", busy_n, model_latency(b, s));
      check("product", {36'b0, product}, exp_p);
      check("in_ready_done", in_ready, 0);
      check("busy_done", busy, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid     = 1'($urandom);
         multiplicand = W'($urandom);
         multiplier   = W'($urandom);
         @(posedge clk);
         #1;
         check("hold_valid", out_valid, 1);
         check("hold_product", {36'b0, product}, exp_p);
         check("hold_in_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("valid_drop", out_valid, 0);
      check("in_ready_back", in_ready, 1);
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_product", {36'b0, product}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      do_op(14'd3, 14'd5, 1'b0, 0);
      check("dir_3x5", {36'b0, product}, 64'd15);
      do_op(14'h3FFF, 14'h3FFF, 1'b0, 0);
      check("dir_max_u", {36'b0, product}, 64'h0FFF8001);
      do_op(14'h3FFF, 14'h3FFF, 1'b1, 0);
      check("dir_m1_m1", {36'b0, product}, 64'd1);
      do_op(14'h2000, 14'h1FFF, 1'b1, 0);
      check("dir_min_x", {36'b0, product}, 64'h0C002000);
      do_op(14'd100, 14'd77, 1'b0, 5);
      do_op(14'd1234, 14'd1, 1'b0, 0);
      check("dir_1234", {36'b0, product}, 64'd1234);

      // reset in the middle of a RUN
      @(negedge clk);
      multiplicand = 14'h3FFF;
      multiplier   = 14'h3FFF;
      signed_mode  = 1'b0;
      in_valid     = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_product", {36'b0, product}, 0);
      @(negedge clk);
      rst = 1'b0;
      do_op(14'd7, 14'd9, 1'b0, 0);
      check("dir_7x9", {36'b0, product}, 64'd63);

      do_op(14'd0, 14'd0, 1'b1, 0);
      do_op(14'h2000, 14'h2000, 1'b1, 1);
      do_op(14'h2000, 14'h2000, 1'b0, 0);

      for (int k = 0; k < 40; k++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
